// File: rtl/input_port.sv
// Parallel input-port holding register for the simple CPU.
// Captures the external data byte when Write is high on a rising clock
// edge and presents it to the datapath until the next write or a reset.
module input_port #(
    parameter int                         WIDTH_DATA_LENGTH = 8,
    parameter logic [WIDTH_DATA_LENGTH-1:0] RESET_VALUE       = '0
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [WIDTH_DATA_LENGTH-1:0] Input,
    input  logic                         Write,
    output logic [WIDTH_DATA_LENGTH-1:0] Output
);

    logic [WIDTH_DATA_LENGTH-1:0] data_d;
    logic [WIDTH_DATA_LENGTH-1:0] data_q;

    // Next-state select: take the new byte on a write, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (Write) begin
            data_d = Input;
        end
    end

    // Holding register; the active-low reset clears it immediately and wins over a write.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign Output = data_q;

endmodule

// File: tb/tb_input_port.sv
// Self-checking bench for the input-port holding register.
// Inputs change on the falling edge; expected values are queued when the
// stimulus is applied and compared against Output on the next falling edge.
module tb_input_port;

   logic       clock;
   logic       rstN;
   logic [7:0] dataIn;
   logic       writeEn;
   logic [7:0] dataOut;

   int checkCount = 0;
   int errorCount = 0;

   logic [7:0] expQ[$];
   string      tagQ[$];

   input_port #(
      .WIDTH_DATA_LENGTH(8),
      .RESET_VALUE(8'h00)
   ) dut (
      .Clk(clock),
      .Rst(rstN),
      .Input(dataIn),
      .Write(writeEn),
      .Output(dataOut)
   );

   // Free-running clock, 10 time-unit period, rising edges at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Pop the oldest expectation and compare it with the current Output.
   task automatic checkOutput();
      logic [7:0] expVal;
      string      tag;
      if (expQ.size() == 0) begin
         checkCount++;
         errorCount++;
         $error("[TB] FAIL scoreboard_empty observed=%h expected=<queued value>", dataOut);
         return;
      end
      expVal = expQ.pop_front();
      tag    = tagQ.pop_front();
      checkCount++;
      assert (dataOut === expVal) else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, dataOut, expVal);
      end
   endtask

   // Drive one cycle of stimulus at a falling edge, queue the result the
   // register must show after the next rising edge, then check it one
   // falling edge later.
   task automatic applyStimulus(input logic rstV, input logic wrV,
                                input logic [7:0] dataV, input logic [7:0] expV,
                                input string tag);
      rstN    = rstV;
      writeEn = wrV;
      dataIn  = dataV;
      expQ.push_back(expV);
      tagQ.push_back(tag);
      @(negedge clock);
      checkOutput();
   endtask

   initial begin
      logic [7:0] walk;

      rstN    = 1'b0;
      writeEn = 1'b1;
      dataIn  = 8'hA5;
      @(negedge clock);

      $display("[TB] reset holds Output at zero despite Write");
      applyStimulus(1'b0, 1'b1, 8'hA5, 8'h00, "reset_write_c1");
      applyStimulus(1'b0, 1'b1, 8'hA5, 8'h00, "reset_write_c2");

      $display("[TB] asynchronous reset after a load");
      applyStimulus(1'b1, 1'b1, 8'h3C, 8'h3C, "load_3c");
      writeEn = 1'b0;
      #2 rstN = 1'b0;
      #1;
      expQ.push_back(8'h00);
      tagQ.push_back("async_reset_mid_cycle");
      checkOutput();
      @(negedge clock);
      #2 rstN = 1'b1;
      @(negedge clock);
      expQ.push_back(8'h00);
      tagQ.push_back("deassert_no_load");
      checkOutput();

      $display("[TB] basic load and hold");
      applyStimulus(1'b1, 1'b1, 8'h5A, 8'h5A, "basic_load_5a");
      applyStimulus(1'b1, 1'b0, 8'hFF, 8'h5A, "hold_in_ff");
      applyStimulus(1'b1, 1'b0, 8'h00, 8'h5A, "hold_in_00");
      applyStimulus(1'b1, 1'b0, 8'h81, 8'h5A, "hold_in_81");

      $display("[TB] back-to-back writes");
      applyStimulus(1'b1, 1'b1, 8'h01, 8'h01, "b2b_01");
      applyStimulus(1'b1, 1'b1, 8'h02, 8'h02, "b2b_02");
      applyStimulus(1'b1, 1'b1, 8'h80, 8'h80, "b2b_80");
      applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF, "b2b_ff");

      $display("[TB] reset priority and recovery");
      applyStimulus(1'b0, 1'b1, 8'hC3, 8'h00, "prio_reset_over_write");
      applyStimulus(1'b1, 1'b0, 8'hC3, 8'h00, "recover_no_write");
      applyStimulus(1'b1, 1'b1, 8'hC3, 8'hC3, "recover_load_c3");

      $display("[TB] walking ones");
      walk = 8'h01;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1, walk, walk, $sformatf("walk_bit%0d", i));
         walk = walk << 1;
      end

      if (expQ.size() != 0) begin
         checkCount++;
         errorCount++;
         $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
